// File: rtl/pattern_editor.sv
// Front-panel step editor with per-drum shadow patterns and a commit handshake into the sequencer bank.
// Optional COMMIT_ALL_EN: one commit loads every drum 0..DRUM_COUNT-1 in sequence.
module pattern_editor #(
  parameter int PATTERN_WIDTH    = 16,
  parameter int DRUM_COUNT       = 5,
  parameter int DRUM_COUNT_WIDTH = 3,
  parameter int CURSOR_WIDTH     = 4,
  parameter int STROBE_CYCLES    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        btn_left_i,
  input  logic                        btn_right_i,
  input  logic                        btn_toggle_i,
  input  logic                        btn_clear_i,
  input  logic                        btn_drum_i,
  input  logic                        btn_commit_i,
  output logic [PATTERN_WIDTH-1:0]    pattern_o,
  output logic [DRUM_COUNT_WIDTH-1:0] sel_o,
  output logic                        en_o_n,
  output logic [CURSOR_WIDTH-1:0]     cursor_o,
  output logic [DRUM_COUNT_WIDTH-1:0] drum_o,
  output logic                        busy_o,
  output logic [DRUM_COUNT-1:0]       dirty_o
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam int CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CURSOR_WIDTH-1:0]     CURSOR_MAX = CURSOR_WIDTH'(PATTERN_WIDTH - 1);
  localparam logic [DRUM_COUNT_WIDTH-1:0] DRUM_MAX   = DRUM_COUNT_WIDTH'(DRUM_COUNT - 1);
  localparam logic [CNT_W-1:0]            CNT_MAX    = CNT_W'(STROBE_CYCLES - 1);

  localparam int B_LEFT   = 0;
  localparam int B_RIGHT  = 1;
  localparam int B_TOGGLE = 2;
  localparam int B_CLEAR  = 3;
  localparam int B_DRUM   = 4;
  localparam int B_COMMIT = 5;

  state_t                      state, state_next;
  logic [DRUM_COUNT_WIDTH-1:0] target, target_next;
  logic [CNT_W-1:0]            cnt, cnt_next;
  logic [PATTERN_WIDTH-1:0]    shadow      [DRUM_COUNT];
  logic [PATTERN_WIDTH-1:0]    shadow_next [DRUM_COUNT];
  logic [5:0]                  btn, btn_prev, press;

  logic [CURSOR_WIDTH-1:0]     cursor_next;
  logic [DRUM_COUNT_WIDTH-1:0] drum_next, sel_next;
  logic [DRUM_COUNT-1:0]       dirty_next;
  logic [PATTERN_WIDTH-1:0]    pattern_next;
  logic                        en_n_next, busy_next;

  assign btn   = {btn_commit_i, btn_drum_i, btn_clear_i, btn_toggle_i, btn_right_i, btn_left_i};
  assign press = btn & ~btn_prev;

  always_comb begin
    state_next  = state;
    target_next = target;
    cnt_next    = cnt;
    shadow_next = shadow;
    cursor_next = cursor_o;
    drum_next   = drum_o;
    dirty_next  = dirty_o;

    case (state)
      IDLE: begin
        if (press[B_RIGHT] && !press[B_LEFT])
          cursor_next = (cursor_o == CURSOR_MAX) ? '0 : cursor_o + 1'b1;
        else if (press[B_LEFT] && !press[B_RIGHT])
          cursor_next = (cursor_o == '0) ? CURSOR_MAX : cursor_o - 1'b1;

        if (press[B_DRUM])
          drum_next = (drum_o == DRUM_MAX) ? '0 : drum_o + 1'b1;

        if (press[B_COMMIT]) begin
          state_next = SETUP;
`ifdef COMMIT_ALL_EN
          target_next = '0;
`else
          target_next = drum_o;
`endif
        end else if (press[B_CLEAR]) begin
          shadow_next[drum_o] = '0;
          dirty_next[drum_o]  = 1'b1;
        end else if (press[B_TOGGLE]) begin
          shadow_next[drum_o][cursor_o] = ~shadow[drum_o][cursor_o];
          dirty_next[drum_o]            = 1'b1;
        end
      end

      SETUP: begin
        state_next = STROBE;
        cnt_next   = '0;
      end

      STROBE: begin
        if (cnt == CNT_MAX) state_next = HOLD;
        else                cnt_next   = cnt + 1'b1;
      end

      HOLD: begin
        dirty_next[target] = 1'b0;
`ifdef COMMIT_ALL_EN
        if (target == DRUM_MAX) begin
          state_next = IDLE;
        end else begin
          state_next  = SETUP;
          target_next = target + 1'b1;
        end
`else
        state_next = IDLE;
`endif
      end

      default: state_next = IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with the state they describe.
    pattern_next = shadow_next[drum_next];
    sel_next     = drum_next;
    en_n_next    = 1'b1;
    busy_next    = (state_next != IDLE);
    if (state_next != IDLE) begin
      pattern_next = shadow[target_next];
      sel_next     = target_next;
    end
    if (state_next == STROBE) en_n_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    btn_prev <= btn;
    if (rst) begin
      state     <= IDLE;
      target    <= '0;
      cnt       <= '0;
      for (int unsigned d = 0; d < DRUM_COUNT; d++) shadow[d] <= '0;
      cursor_o  <= '0;
      drum_o    <= '0;
      dirty_o   <= '0;
      pattern_o <= '0;
      sel_o     <= '0;
      en_o_n    <= 1'b1;
      busy_o    <= 1'b0;
    end else begin
      state     <= state_next;
      target    <= target_next;
      cnt       <= cnt_next;
      shadow    <= shadow_next;
      cursor_o  <= cursor_next;
      drum_o    <= drum_next;
      dirty_o   <= dirty_next;
      pattern_o <= pattern_next;
      sel_o     <= sel_next;
      en_o_n    <= en_n_next;
      busy_o    <= busy_next;
    end
  end

endmodule

// File: tb/tb_pattern_editor.sv
// Scoreboard bench for pattern_editor: stimulus queues expected strobes/busy lengths, a monitor checks them.
module tb_pattern_editor;
`ifdef COMMIT_ALL_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int D = 5;

  localparam logic [5:0] LEFT = 6'b000001, RIGHT = 6'b000010, TOGGLE = 6'b000100,
                         CLEAR = 6'b001000, DRUM = 6'b010000, COMMIT = 6'b100000;

  logic        clk = 1'b0, rst = 1'b1;
  logic [5:0]  btns = '0;
  logic [15:0] pattern_o;
  logic [2:0]  sel_o, drum_o;
  logic [3:0]  cursor_o;
  logic        en_o_n, busy_o;
  logic [4:0]  dirty_o;

  pattern_editor #(.PATTERN_WIDTH(16), .DRUM_COUNT(D), .DRUM_COUNT_WIDTH(3),
                   .CURSOR_WIDTH(4), .STROBE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .btn_left_i(btns[0]), .btn_right_i(btns[1]), .btn_toggle_i(btns[2]),
    .btn_clear_i(btns[3]), .btn_drum_i(btns[4]), .btn_commit_i(btns[5]),
    .pattern_o(pattern_o), .sel_o(sel_o), .en_o_n(en_o_n), .cursor_o(cursor_o),
    .drum_o(drum_o), .busy_o(busy_o), .dirty_o(dirty_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] sel; logic [15:0] pat; } strobe_t;
  strobe_t     exp_strobe[$];
  int          exp_busy[$];
  int          tests = 0, fails = 0;
  logic [15:0] sh [D];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [5:0] m);
    @(posedge clk); #1 btns = m;
    @(posedge clk); #1 btns = '0;
  endtask

  task automatic push_commit(input int drum);
    strobe_t e;
`ifdef COMMIT_ALL_EN
    for (int d = 0; d < D; d++) begin
      e.sel = 3'(d); e.pat = sh[d]; exp_strobe.push_back(e);
    end
    exp_busy.push_back(D * (S + 2));
`else
    e.sel = 3'(drum); e.pat = sh[drum]; exp_strobe.push_back(e);
    exp_busy.push_back(S + 2);
`endif
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy_o && n < 100) begin @(negedge clk); n++; end
    check("commit_done", busy_o, 0);
  endtask

  // Monitor: strobe runs and busy windows are compared against the queues.
  int          run = 0, brun = 0;
  logic [2:0]  csel;
  logic [15:0] cpat;
  always @(negedge clk) begin
    strobe_t e;
    int b;
    if (rst) begin
      run = 0; brun = 0;
    end else begin
      if (!en_o_n) begin
        if (run == 0) begin csel = sel_o; cpat = pattern_o; end
        else check("strobe_stable", {sel_o, pattern_o}, {csel, cpat});
        run++;
      end else if (run > 0) begin
        tests++;
        if (exp_strobe.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe: got sel %0d pattern %0h required none", csel, cpat);
        end else begin
          tests--;
          e = exp_strobe.pop_front();
          check("strobe_sel", csel, e.sel);
          check("strobe_pattern", cpat, e.pat);
          check("strobe_len", run, S);
        end
        run = 0;
      end
      if (busy_o) brun++;
      else if (brun > 0) begin
        tests++;
        if (exp_busy.size() == 0) begin
          fails++;
          $display("FAIL unexpected_busy: got %0d cycles required none", brun);
        end else begin
          tests--;
          b = exp_busy.pop_front();
          check("busy_len", brun, b);
        end
        brun = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    int n;
    for (int d = 0; d < D; d++) sh[d] = '0;

    // Reset with commit held through it
    btns = COMMIT;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_en", en_o_n, 1);
    check("rst_busy", busy_o, 0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy_o, 0);
    check("post_rst_en", en_o_n, 1);
    check("post_rst_cursor", cursor_o, 0);
    check("post_rst_drum", drum_o, 0);
    check("post_rst_dirty", dirty_o, 0);
    check("post_rst_pattern", pattern_o, 0);
    check("post_rst_sel", sel_o, 0);
    @(posedge clk); #1 btns = '0;

    // Cursor wrap
    repeat (17) press(RIGHT);
    @(negedge clk); check("cursor_17_right", cursor_o, 1);
    press(LEFT);
    @(negedge clk); check("cursor_left", cursor_o, 0);
    press(LEFT);
    @(negedge clk); check("cursor_wrap_left", cursor_o, 15);
    press(LEFT | RIGHT);
    @(negedge clk); check("cursor_both", cursor_o, 15);
    repeat (4) press(RIGHT);
    @(negedge clk); check("cursor_3", cursor_o, 3);

    // Toggle and commit drum 2
    repeat (2) press(DRUM);
    @(negedge clk); check("drum_2", drum_o, 2);
    check("idle_sel", sel_o, 2);
    press(TOGGLE); sh[2] = 16'h0008;
    @(negedge clk); check("toggle_pattern", pattern_o, 16'h0008);
    check("toggle_dirty", dirty_o, 5'b00100);
    push_commit(2);
    press(COMMIT);
    wait_idle();
    check("commit_dirty", dirty_o, 0);
    check("commit_en_idle", en_o_n, 1);
    check("commit_idle_pattern", pattern_o, 16'h0008);

    // Commit beats clear and toggle in the same cycle
    push_commit(2);
    press(TOGGLE | CLEAR | COMMIT);
    wait_idle();
    check("prio_pattern", pattern_o, 16'h0008);
    check("prio_dirty", dirty_o, 0);

    // Edits during busy are dropped
    push_commit(2);
    press(COMMIT);
    press(TOGGLE);
    wait_idle();
    @(negedge clk);
    check("busy_drop_pattern", pattern_o, 16'h0008);
    check("busy_drop_dirty", dirty_o, 0);

    // Clear wins over toggle
    press(CLEAR | TOGGLE); sh[2] = '0;
    @(negedge clk); check("clear_pattern", pattern_o, 0);
    check("clear_dirty", dirty_o, 5'b00100);

    // Drum wrap then edit drum 0
    repeat (3) press(DRUM);
    @(negedge clk); check("drum_wrap", drum_o, 0);
    press(TOGGLE); sh[0] = 16'h0008;
    @(negedge clk); check("drum0_pattern", pattern_o, 16'h0008);
    check("drum0_dirty", dirty_o, 5'b00101);

    // Reset during strobe
    press(COMMIT);
    n = 0;
    @(negedge clk);
    while (en_o_n && n < 20) begin @(negedge clk); n++; end
    check("strobe_seen", en_o_n, 0);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_en", en_o_n, 1);
    check("abort_busy", busy_o, 0);
    check("abort_dirty", dirty_o, 0);
    check("abort_pattern", pattern_o, 0);
    check("abort_cursor", cursor_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int d = 0; d < D; d++) sh[d] = '0;
    repeat (2) press(DRUM);
    @(negedge clk); check("abort_shadow2", pattern_o, 0);
    check("abort_sel2", sel_o, 2);

    repeat (5) @(negedge clk);
    check("strobe_queue_empty", exp_strobe.size(), 0);
    check("busy_queue_empty", exp_busy.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
